result_checker: RTL and testbench

- Clocked consumer placed directly downstream of a combinational or pipelined LUT-optimisation DUT; one instance per DUT output.
- Delays the expected value to line up with DUT latency, compares it against the DUT output on each valid cycle, and counts mismatches over a fixed-length run.
- Raises done/pass at the end of the run; optionally captures the first mismatch.
- Synthesizable, so it can sit in simulation benches and in on-chip self-test wrappers.

---
 rtl/result_checker_pkg.sv | 18 +
 rtl/checker_delay_line.sv | 35 +++
 rtl/result_checker.sv | 164 ++++++++++++++++
 tb/tb_result_checker.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_checker_pkg.sv
// Shared types and helpers for the result_checker slice.
package result_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int MAX_EXP_DELAY = 7;

  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/checker_delay_line.sv
// Flushable shift register that realigns {valid, exp} with DUT latency; DEPTH=0 is a wire.
module checker_delay_line #(
  parameter int W     = 4,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, flush_i};
    assign data_o    = data_i;
  end else begin : g_pipe
    logic [W-1:0] stage_q [DEPTH];

    // NOTE: every stage is reset so a stale valid bit can never reach the comparator.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (flush_i) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign data_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/result_checker.sv
// Latency-aligned compare-and-count checker for one DUT output.
// Define RESULT_CHECKER_CAPTURE_EN to latch the first mismatch of each run.
module result_checker
  import result_checker_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int EXP_DELAY  = 0,
  parameter int RUN_CYCLES = 10000,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid,
  input  logic [WIDTH-1:0] act,
  input  logic [WIDTH-1:0] exp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [WIDTH-1:0] first_act,
  output logic [WIDTH-1:0] first_exp,
  output logic [CNT_W-1:0] first_cyc
);

  // Out-of-range depths clamp to the deepest supported delay line.
  localparam int               DLY       = (EXP_DELAY > MAX_EXP_DELAY) ? MAX_EXP_DELAY : EXP_DELAY;
  localparam int               RUN_W     = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(RUN_CYCLES - 1);
  localparam logic [2:0]       FILL_LAST = 3'(DLY - 1);
  localparam logic [31:0]      CNT_MAX   = 32'((64'd1 << CNT_W) - 64'd1);

  state_e             state_q, state_d;
  logic               start_run;
  logic [2:0]         fill_cnt_q, fill_cnt_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               err_pulse_q, err_pulse_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     dly_out;
  logic               d_valid;
  logic [WIDTH-1:0]   d_exp;
  logic               mismatch;

  checker_delay_line #(
    .W     (WIDTH + 1),
    .DEPTH (DLY)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .flush_i (start_run),
    .data_i  ({valid, exp}),
    .data_o  (dly_out)
  );

  assign {d_valid, d_exp} = dly_out;
  assign mismatch         = (state_q == ST_RUN) && d_valid && (act != d_exp);

  // NOTE: every variable gets its default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    start_run   = 1'b0;
    fill_cnt_d  = fill_cnt_q;
    run_cnt_d   = run_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_run   = 1'b1;
          state_d     = (DLY > 0) ? ST_FILL : ST_RUN;
          fill_cnt_d  = '0;
          run_cnt_d   = '0;
          cycle_cnt_d = '0;
          err_cnt_d   = '0;
        end
      end
      ST_FILL: begin
        fill_cnt_d = fill_cnt_q + 3'd1;
        if (fill_cnt_q == FILL_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        run_cnt_d   = run_cnt_q + 1'b1;
        cycle_cnt_d = cycle_cnt_q + 1'b1;
        if (mismatch) begin
          err_pulse_d = 1'b1;
          err_cnt_d   = CNT_W'(sat_inc(32'(err_cnt_q), CNT_MAX));
        end
        if (run_cnt_q == RUN_LAST) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_FILL) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fill_cnt_q  <= '0;
      run_cnt_q   <= '0;
      cycle_cnt_q <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      run_cnt_q   <= run_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef RESULT_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0] first_act_q, first_exp_q;
  logic [CNT_W-1:0] first_cyc_q;

  // err_cnt_q is still zero only until the first mismatch of the run is counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_act_q <= '0;
      first_exp_q <= '0;
      first_cyc_q <= '0;
    end else if (start_run) begin
      first_act_q <= '0;
      first_exp_q <= '0;
      first_cyc_q <= '0;
    end else if (mismatch && (err_cnt_q == '0)) begin
      first_act_q <= act;
      first_exp_q <= d_exp;
      first_cyc_q <= cycle_cnt_q;
    end
  end

  assign first_act = first_act_q;
  assign first_exp = first_exp_q;
  assign first_cyc = first_cyc_q;
`else
  assign first_act = '0;
  assign first_exp = '0;
  assign first_cyc = '0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = done_q && (err_cnt_q == '0);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_result_checker.sv
// Scoreboard bench for result_checker: directed runs on four instances of different configuration.
module tb_result_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int done_cyc;
    int err;
    int cyc;
    bit pass;
    int fa;
    int fe;
    int fc;
  } expect_t;

  expect_t q_a[$], q_b[$], q_c[$], q_d[$];
  int      q_pulse[$];

  // Instance a: WIDTH=3, EXP_DELAY=0, RUN_CYCLES=8
  logic        a_start = 0, a_valid = 0;
  logic [2:0]  a_act = 0, a_exp = 0;
  logic        a_busy, a_done, a_pass, a_err_pulse;
  logic [15:0] a_err_cnt, a_cycle_cnt, a_first_cyc;
  logic [2:0]  a_first_act, a_first_exp;

  result_checker #(.WIDTH(3), .EXP_DELAY(0), .RUN_CYCLES(8), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .valid(a_valid), .act(a_act), .exp(a_exp),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_pulse(a_err_pulse),
    .err_cnt(a_err_cnt), .cycle_cnt(a_cycle_cnt),
    .first_act(a_first_act), .first_exp(a_first_exp), .first_cyc(a_first_cyc));

  // Instances b (EXP_DELAY=2) and c (EXP_DELAY=1) watch a DUT model with two register stages
  logic        bc_start = 0, bc_valid = 0;
  logic [2:0]  bc_x = 0, bc_p1, bc_p2;
  logic        b_busy, b_done, b_pass, b_err_pulse, c_busy, c_done, c_pass, c_err_pulse;
  logic [15:0] b_err_cnt, b_cycle_cnt, b_first_cyc, c_err_cnt, c_cycle_cnt, c_first_cyc;
  logic [2:0]  b_first_act, b_first_exp, c_first_act, c_first_exp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bc_p1 <= '0;
      bc_p2 <= '0;
    end else begin
      bc_p1 <= bc_x;
      bc_p2 <= bc_p1;
    end
  end

  result_checker #(.WIDTH(3), .EXP_DELAY(2), .RUN_CYCLES(8), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .start(bc_start), .valid(bc_valid), .act(bc_p2), .exp(bc_x),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_pulse(b_err_pulse),
    .err_cnt(b_err_cnt), .cycle_cnt(b_cycle_cnt),
    .first_act(b_first_act), .first_exp(b_first_exp), .first_cyc(b_first_cyc));

  result_checker #(.WIDTH(3), .EXP_DELAY(1), .RUN_CYCLES(8), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .start(bc_start), .valid(bc_valid), .act(bc_p2), .exp(bc_x),
    .busy(c_busy), .done(c_done), .pass(c_pass), .err_pulse(c_err_pulse),
    .err_cnt(c_err_cnt), .cycle_cnt(c_cycle_cnt),
    .first_act(c_first_act), .first_exp(c_first_exp), .first_cyc(c_first_cyc));

  // Instance d: CNT_W=4, RUN_CYCLES=20 for saturation and cycle wrap
  logic        d_start = 0, d_valid = 0;
  logic [2:0]  d_act = 0, d_exp = 0;
  logic        d_busy, d_done, d_pass, d_err_pulse;
  logic [3:0]  d_err_cnt, d_cycle_cnt, d_first_cyc;
  logic [2:0]  d_first_act, d_first_exp;

  result_checker #(.WIDTH(3), .EXP_DELAY(0), .RUN_CYCLES(20), .CNT_W(4)) u_d (
    .clk(clk), .rst(rst), .start(d_start), .valid(d_valid), .act(d_act), .exp(d_exp),
    .busy(d_busy), .done(d_done), .pass(d_pass), .err_pulse(d_err_pulse),
    .err_cnt(d_err_cnt), .cycle_cnt(d_cycle_cnt),
    .first_act(d_first_act), .first_exp(d_first_exp), .first_cyc(d_first_cyc));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, tcyc);
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    $display("FAIL %s: event seen at cycle %0d, want none", name, tcyc);
  endtask

  task automatic check_result(input string tag, input expect_t e, input int got_err,
                              input int got_cyc, input logic got_pass);
    check({tag, "_done_cyc"}, tcyc, e.done_cyc);
    check({tag, "_err_cnt"}, got_err, e.err);
    check({tag, "_cycle_cnt"}, got_cyc, e.cyc);
    check({tag, "_pass"}, {31'd0, got_pass}, {31'd0, e.pass});
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_busy"}, a_busy, 0);
    check({tag, "_done"}, a_done, 0);
    check({tag, "_pass"}, a_pass, 0);
    check({tag, "_err_pulse"}, a_err_pulse, 0);
    check({tag, "_err_cnt"}, a_err_cnt, 0);
    check({tag, "_cycle_cnt"}, a_cycle_cnt, 0);
    check({tag, "_first_act"}, a_first_act, 0);
    check({tag, "_first_exp"}, a_first_exp, 0);
    check({tag, "_first_cyc"}, a_first_cyc, 0);
  endtask

  // Monitors: pop the scoreboard on each done rising edge and on every err_pulse of instance a
  logic    a_done_prev = 0, b_done_prev = 0, c_done_prev = 0, d_done_prev = 0;
  expect_t ea, eb, ec, ed;
  int      ep;

  always @(negedge clk) begin
    if (a_done && !a_done_prev) begin
      if (q_a.size() == 0) fail_event("a_done");
      else begin
        ea = q_a.pop_front();
        check_result("a", ea, a_err_cnt, a_cycle_cnt, a_pass);
`ifdef RESULT_CHECKER_CAPTURE_EN
        check("a_first_act", a_first_act, ea.fa);
        check("a_first_exp", a_first_exp, ea.fe);
        check("a_first_cyc", a_first_cyc, ea.fc);
`else
        check("a_first_act", a_first_act, 0);
        check("a_first_exp", a_first_exp, 0);
        check("a_first_cyc", a_first_cyc, 0);
`endif
      end
    end
    if (a_err_pulse) begin
      if (q_pulse.size() == 0) fail_event("a_err_pulse");
      else begin
        ep = q_pulse.pop_front();
        check("a_err_pulse_cyc", tcyc, ep);
      end
    end
    a_done_prev <= a_done;
  end

  always @(negedge clk) begin
    if (b_done && !b_done_prev) begin
      if (q_b.size() == 0) fail_event("b_done");
      else begin
        eb = q_b.pop_front();
        check_result("b", eb, b_err_cnt, b_cycle_cnt, b_pass);
      end
    end
    b_done_prev <= b_done;
  end

  always @(negedge clk) begin
    if (c_done && !c_done_prev) begin
      if (q_c.size() == 0) fail_event("c_done");
      else begin
        ec = q_c.pop_front();
        check_result("c", ec, c_err_cnt, c_cycle_cnt, c_pass);
      end
    end
    c_done_prev <= c_done;
  end

  always @(negedge clk) begin
    if (d_done && !d_done_prev) begin
      if (q_d.size() == 0) fail_event("d_done");
      else begin
        ed = q_d.pop_front();
        check_result("d", ed, d_err_cnt, d_cycle_cnt, d_pass);
      end
    end
    d_done_prev <= d_done;
  end

  // bad: act=5 vs exp=4 on that RUN cycle; vld: valid per cycle; stp: start pulses during RUN.
  // n_run < 8 leaves the run in progress and pushes no result.
  task automatic run_a(input logic [7:0] bad, input logic [7:0] vld,
                       input logic [7:0] stp, input int n_run);
    expect_t e;
    bit      first_seen;
    e          = '{default: 0};
    first_seen = 0;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    check("a_busy_after_start", a_busy, 1);
    check("a_err_cnt_cleared", a_err_cnt, 0);
    check("a_cycle_cnt_cleared", a_cycle_cnt, 0);
    check("a_first_act_cleared", a_first_act, 0);
    for (int c = 0; c < n_run; c++) begin
      a_valid = vld[c];
      a_start = stp[c];
      if (bad[c]) begin
        a_exp = 3'd4;
        a_act = 3'd5;
      end else begin
        a_exp = 3'(c + 17);
        a_act = 3'(c + 17);
      end
      if (bad[c] && vld[c]) begin
        q_pulse.push_back(tcyc + 1);
        e.err++;
        if (!first_seen) begin
          first_seen = 1;
          e.fa = 5;
          e.fe = 4;
          e.fc = c;
        end
      end
      @(posedge clk); #1;
    end
    a_start = 1'b0;
    a_valid = 1'b0;
    if (n_run == 8) begin
      e.done_cyc = tcyc;
      e.cyc      = 8;
      e.pass     = (e.err == 0);
      q_a.push_back(e);
    end
  endtask

  task automatic run_bc();
    int t0;
    bc_start = 1'b1;
    @(posedge clk); #1;
    bc_start = 1'b0;
    t0 = tcyc;
    check("b_busy_fill", b_busy, 1);
    check("c_busy_fill", c_busy, 1);
    // b: 2 FILL + 8 RUN, aligned. c: 1 FILL + 8 RUN, one cycle short, every sample differs.
    q_b.push_back('{done_cyc: t0 + 10, err: 0, cyc: 8, pass: 1, fa: 0, fe: 0, fc: 0});
    q_c.push_back('{done_cyc: t0 + 9,  err: 8, cyc: 8, pass: 0, fa: 0, fe: 0, fc: 0});
    for (int i = 0; i < 10; i++) begin
      bc_valid = 1'b1;
      bc_x     = 3'(3 * i + 1);
      @(posedge clk); #1;
      if (i == 1) check("b_cycle_cnt_after_fill", b_cycle_cnt, 0);
    end
    bc_valid = 1'b0;
    bc_x     = '0;
  endtask

  task automatic run_d();
    int t0;
    d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    t0 = tcyc;
    q_d.push_back('{done_cyc: t0 + 20, err: 15, cyc: 4, pass: 0, fa: 0, fe: 0, fc: 0});
    for (int i = 0; i < 20; i++) begin
      d_valid = 1'b1;
      d_exp   = 3'(i);
      d_act   = ~3'(i);
      @(posedge clk); #1;
    end
    d_valid = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_a_zero("reset");
    check("b_busy_reset", b_busy, 0);
    check("d_err_cnt_reset", d_err_cnt, 0);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    run_a(8'h00, 8'hFF, 8'h00, 8);
    run_a(8'b0010_0100, 8'hFF, 8'h00, 8);
    run_a(8'b0100_0010, 8'b1111_1101, 8'b0001_1000, 8);
    run_a(8'b0000_0001, 8'hFF, 8'h00, 3);
    check("a_cycle_cnt_before_abort", a_cycle_cnt, 3);
    rst = 1'b1;
    #1;
    check_a_zero("abort");
    #3 rst = 1'b0;
    @(posedge clk); #1;
    run_a(8'h00, 8'hFF, 8'h00, 8);

    run_bc();
    run_d();

    repeat (4) @(posedge clk);
    #1;
    check("a_results_left", q_a.size(), 0);
    check("a_pulses_left", q_pulse.size(), 0);
    check("b_results_left", q_b.size(), 0);
    check("c_results_left", q_c.size(), 0);
    check("d_results_left", q_d.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want run complete");
    $fatal(1, "watchdog");
  end

endmodule
